if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning the instruction driven while id_valid_o=0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port addr, output, 12 bits: byte fetch address to the instruction ROM.
REQ-006 SHALL have port ce, output, 1 bit: ROM fetch enable.
REQ-007 SHALL have port inst, input, 32 bits: ROM read data, combinationally valid in the same cycle as addr while ce=1.
REQ-008 SHALL have port stall_i, input, 1 bit: decode cannot accept; the IF/ID outputs hold.
REQ-009 SHALL have port branch_flag_i, input, 1 bit: redirect request.
REQ-010 SHALL have port branch_addr_i, input, 12 bits: redirect target.
REQ-011 SHALL have port id_inst_o, output, 32 bits: registered instruction to decode.
REQ-012 SHALL have port id_pc_o, output, 12 bits: registered address of id_inst_o.
REQ-013 SHALL have port id_valid_o, output, 1 bit: id_inst_o/id_pc_o hold a real fetched instruction.

Function
REQ-014 SHALL keep a 12-bit pc register; addr SHALL equal pc.
REQ-015 SHALL keep bits [1:0] of pc at 0 at all times; branch_addr_i[1:0] SHALL be ignored.
REQ-016 SHALL advance pc by 4 per accepted fetch, modulo 4096, so 12'hFFC is followed by 12'h000.
REQ-017 SHALL use a 3-state FSM: IDLE, FETCH, HOLD.
REQ-018 SHALL move IDLE to FETCH unconditionally one cycle after reset is released; ce SHALL be 0 in IDLE.
REQ-019 SHALL move FETCH to HOLD when buffer count becomes 2.
REQ-020 SHALL move HOLD to FETCH when count drops below 2, or on a branch.
REQ-021 SHALL contain a 2-entry FIFO prefetch buffer, each entry holding {inst, pc}, with count in the range 0..2.
REQ-022 SHALL drive ce = (state==FETCH) && (count<2) && !branch_flag_i, combinationally.
REQ-023 SHALL treat a fetch as accepted in every cycle with ce=1, sampling inst and pc that cycle.
REQ-024 SHALL, when stall_i=0 and count>0, load the IF/ID outputs from the buffer head; any accepted fetch that cycle SHALL enqueue at the tail.
REQ-025 SHALL, when stall_i=0, count=0 and a fetch is accepted, load the IF/ID outputs directly from inst/pc (bypass, 1-cycle latency).
REQ-026 SHALL, when stall_i=0 and nothing is available, set id_valid_o=0 and id_inst_o=NOP_INST next cycle.
REQ-027 SHALL, when stall_i=1, hold the IF/ID outputs and enqueue any accepted fetch; a simultaneous dequeue and enqueue SHALL leave count unchanged.
REQ-028 SHALL never overflow the buffer, since ce=0 at count=2; a fetch with count=2 SHALL be impossible.
REQ-029 SHALL, on branch_flag_i=1 (priority over stall_i):
  - set pc <= {branch_addr_i[11:2],2'b00} and count <= 0;
  - set id_valid_o <= 0 and id_inst_o <= NOP_INST;
  - set state <= FETCH;
  - fetch nothing that cycle.
REQ-030 SHALL present the first post-branch instruction on the IF/ID outputs 2 cycles after branch_flag_i is sampled, given stall_i=0.
REQ-031 SHALL NOT change pc while ce=0, except on branch or reset.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, regardless of any in-flight operation, set:
  - pc=RESET_PC, state=IDLE, count=0;
  - id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=12'h000.
REQ-033 SHALL force ce=0 combinationally while rst=1.
REQ-034 SHALL give rst priority over branch_flag_i and stall_i.

Verification
REQ-035 Reset release test: ROM word n = n, no stall -> ce=1 from cycle 2; id_inst_o sequence 0,1,2... with id_pc_o 000,004,008...; id_valid_o=1 from cycle 3.
REQ-036 Stall test: stall_i held 4 cycles mid-stream at id_pc_o=010 -> outputs hold at 010; count reaches 2; ce=0 in HOLD; on release outputs show 014, 018, 01C with no gaps or duplicates.
REQ-037 Branch test: branch_flag_i with branch_addr_i=12'h123 while count=2 and stall_i=1 -> pc=120; buffer flushed; id_valid_o=0 next cycle; id_pc_o=120 two cycles later.
REQ-038 Wrap test: branch to FF8, no stall -> id_pc_o sequence FF8, FFC, 000, 004.
REQ-039 Reset mid-operation test: rst asserted with count=2 and stall_i=1 -> next cycle all outputs at reset values, ce=0; restart fetches from RESET_PC.
REQ-040 Random test: random stall_i and branch stimulus against a reference model -> no instruction lost, duplicated or reordered; count never exceeds 2.

Source files
------------

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage with a 2-entry prefetch FIFO in front of the IF/ID
// pipeline register. It fetches sequentially from a combinational instruction
// ROM. It keeps fetching while decode is stalled until the buffer is full. A
// branch redirects the PC and flushes everything in flight.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   addr    [11:0] out  byte fetch address (equals pc)
//   ce             out  ROM fetch enable; a fetch is accepted every cycle ce=1
//   inst    [31:0] in   ROM read data, valid in the same cycle as addr
//   stall_i        in   decode cannot accept; IF/ID outputs hold
//   branch_flag_i  in   redirect request (priority over stall_i)
//   branch_addr_i  in   redirect target, low two bits ignored
//   id_inst_o      out  registered instruction to decode
//   id_pc_o        out  registered address of id_inst_o
//   id_valid_o     out  id_inst_o/id_pc_o hold a real fetched instruction
//
// States
//   IDLE  | first cycle after reset, no fetching
//   FETCH | fetching while the buffer has room
//   HOLD  | buffer full, fetching paused until decode drains an entry
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] addr,
  output logic        ce,
  input  logic [31:0] inst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [11:0] branch_addr_i,
  output logic [31:0] id_inst_o,
  output logic [11:0] id_pc_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_pc;
  logic [1:0]  r_count;

  // FIFO storage: entry 0 is always the head.
  logic [31:0] r_buf0_inst;
  logic [11:0] r_buf0_pc;
  logic [31:0] r_buf1_inst;
  logic [11:0] r_buf1_pc;

  logic        w_ce;
  logic        w_deq;
  logic        w_bypass;
  logic        w_enq;
  logic        w_tail;
  logic [1:0]  w_count_nxt;

  always_comb begin
    w_ce        = 1'b0;
    w_deq       = 1'b0;
    w_bypass    = 1'b0;
    w_enq       = 1'b0;
    w_tail      = 1'b0;
    w_count_nxt = r_count;
    w_state_nxt = r_state;

    w_ce     = !rst && (r_state == S_FETCH) && (r_count < 2'd2) && !branch_flag_i;
    w_deq    = !stall_i && (r_count != 2'd0);
    // An empty buffer with decode ready sends the fetched word straight to
    // IF/ID, so it never occupies a buffer slot.
    w_bypass = w_ce && !stall_i && (r_count == 2'd0);
    w_enq    = w_ce && !w_bypass;
    // After a dequeue the surviving entry shifts to slot 0, so the new tail
    // lands in slot 1 only when one entry remains un-popped.
    w_tail   = (r_count == 2'd1) && !w_deq;
    w_count_nxt = r_count + {1'b0, w_enq} - {1'b0, w_deq};

    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (w_count_nxt == 2'd2) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_count_nxt < 2'd2)  w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase

    if (branch_flag_i) w_state_nxt = S_FETCH;
  end

  assign ce   = w_ce;
  assign addr = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC & 12'hFFC;
      r_count     <= 2'd0;
      id_valid_o  <= 1'b0;
      id_inst_o   <= NOP_INST;
      id_pc_o     <= 12'h000;
      r_buf0_inst <= NOP_INST;
      r_buf0_pc   <= 12'h000;
      r_buf1_inst <= NOP_INST;
      r_buf1_pc   <= 12'h000;
    end else begin
      r_state <= w_state_nxt;
      if (branch_flag_i) begin
        r_pc       <= branch_addr_i & 12'hFFC;
        r_count    <= 2'd0;
        id_valid_o <= 1'b0;
        id_inst_o  <= NOP_INST;
      end else begin
        r_count <= w_count_nxt;
        if (w_ce) r_pc <= r_pc + 12'd4;

        if (!stall_i) begin
          if (r_count != 2'd0) begin
            id_inst_o  <= r_buf0_inst;
            id_pc_o    <= r_buf0_pc;
            id_valid_o <= 1'b1;
          end else if (w_bypass) begin
            id_inst_o  <= inst;
            id_pc_o    <= r_pc;
            id_valid_o <= 1'b1;
          end else begin
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
          end
        end

        if (w_deq) begin
          r_buf0_inst <= r_buf1_inst;
          r_buf0_pc   <= r_buf1_pc;
        end
        // Written after the shift so a same-cycle enqueue into slot 0 wins.
        if (w_enq) begin
          if (w_tail) begin
            r_buf1_inst <= inst;
            r_buf1_pc   <= r_pc;
          end else begin
            r_buf0_inst <= inst;
            r_buf0_pc   <= r_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [11:0] RESET_PC = 12'h000;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        ce;
  logic [31:0] inst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [11:0] branch_addr_i;
  logic [31:0] id_inst_o;
  logic [11:0] id_pc_o;
  logic        id_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  // ROM: word n holds n; garbage when not enabled.
  assign inst = ce ? {22'h0, addr[11:2]} : 32'hDEADBEEF;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .ce           (ce),
    .inst         (inst),
    .stall_i      (stall_i),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .id_inst_o    (id_inst_o),
    .id_pc_o      (id_pc_o),
    .id_valid_o   (id_valid_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected instruction stream restarts at every redirect or reset release.
  task automatic restart(input logic [11:0] start);
    logic [11:0] p;
    exp_q.delete();
    p = start & 12'hFFC;
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back(p);
      p = p + 12'd4;
    end
  endtask

  // Monitor: a new instruction is presented after every edge where decode
  // was ready and no reset/branch occurred.
  initial begin
    logic s_rst, s_br, s_st;
    logic [11:0] e;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_br  = branch_flag_i;
      s_st  = stall_i;
      #1;
      if (!s_rst && !s_br && !s_st && id_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty actual=%h expected=<none> t=%0t", id_pc_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", {20'h0, id_pc_o}, {20'h0, e});
          chk("sb_inst", id_inst_o, {22'h0, e[11:2]});
        end
      end
      if (id_valid_o === 1'b0) chk("nop_inst", id_inst_o, NOP_INST);
      chk("count_max", {31'h0, (dut.r_count <= 2'd2)}, 32'd1);
    end
  end

  initial begin
    logic found;
    rst           = 1'b1;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    branch_addr_i = 12'h000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ce", {31'h0, ce}, 32'd0);
    chk("rst_valid", {31'h0, id_valid_o}, 32'd0);
    chk("rst_inst", id_inst_o, NOP_INST);
    chk("rst_pc", {20'h0, id_pc_o}, 32'h000);
    chk("rst_addr", {20'h0, addr}, {20'h0, RESET_PC});

    // Reset release
    rst = 1'b0;
    restart(RESET_PC);
    #1 chk("idle_ce", {31'h0, ce}, 32'd0);
    @(negedge clk);
    chk("fetch_ce", {31'h0, ce}, 32'd1);
    chk("fetch_addr", {20'h0, addr}, 32'h000);
    @(negedge clk);
    chk("first_valid", {31'h0, id_valid_o}, 32'd1);
    chk("first_pc", {20'h0, id_pc_o}, 32'h000);
    chk("first_inst", id_inst_o, 32'd0);

    // Stall at 010
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (id_pc_o == 12'h010) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_010", {31'h0, found}, 32'd1);
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_pc", {20'h0, id_pc_o}, 32'h010);
      chk("stall_hold_valid", {31'h0, id_valid_o}, 32'd1);
      if (i >= 1) chk("hold_ce", {31'h0, ce}, 32'd0);
    end
    stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("release_pc", {20'h0, id_pc_o}, 32'h014 + 32'(4 * i));
    end

    // Branch with full buffer and stall
    stall_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_ce", {31'h0, ce}, 32'd0);
    branch_flag_i = 1'b1;
    branch_addr_i = 12'h123;
    restart(12'h123);
    #1 chk("br_ce", {31'h0, ce}, 32'd0);
    @(negedge clk);
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    chk("br_addr", {20'h0, addr}, 32'h120);
    chk("br_valid", {31'h0, id_valid_o}, 32'd0);
    chk("br_inst", id_inst_o, NOP_INST);
    #1 chk("br_ce_after", {31'h0, ce}, 32'd1);
    @(negedge clk);
    chk("br_tgt_valid", {31'h0, id_valid_o}, 32'd1);
    chk("br_tgt_pc", {20'h0, id_pc_o}, 32'h120);

    // Wrap
    branch_flag_i = 1'b1;
    branch_addr_i = 12'hFF8;
    restart(12'hFF8);
    @(negedge clk);
    branch_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [11:0] w;
      w = 12'hFF8 + 12'(4 * i);
      @(negedge clk);
      chk("wrap_pc", {20'h0, id_pc_o}, {20'h0, w});
    end

    // Reset mid-operation
    stall_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_ce_comb", {31'h0, ce}, 32'd0);
    @(negedge clk);
    chk("rst_mid_valid", {31'h0, id_valid_o}, 32'd0);
    chk("rst_mid_inst", id_inst_o, NOP_INST);
    chk("rst_mid_pc", {20'h0, id_pc_o}, 32'h000);
    chk("rst_mid_addr", {20'h0, addr}, {20'h0, RESET_PC});
    chk("rst_mid_ce", {31'h0, ce}, 32'd0);
    rst     = 1'b0;
    stall_i = 1'b0;
    restart(RESET_PC);
    @(negedge clk);
    chk("restart_ce", {31'h0, ce}, 32'd1);
    chk("restart_addr", {20'h0, addr}, {20'h0, RESET_PC});
    @(negedge clk);
    chk("restart_pc", {20'h0, id_pc_o}, {20'h0, RESET_PC});

    // Random stall/branch against the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall_i = ($urandom % 3 == 0);
      if ($urandom % 20 == 0) begin
        branch_flag_i = 1'b1;
        branch_addr_i = 12'($urandom);
        restart(branch_addr_i);
      end else begin
        branch_flag_i = 1'b0;
      end
    end
    @(negedge clk);
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
